// File: rtl/icache_pkg.sv
// Shared definitions for the direct-mapped instruction cache: FSM states,
// default geometry and address-field widths.
package icache_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_REQ     = 2'd1,
        ST_REFILL  = 2'd2,
        ST_RESPOND = 2'd3
    } state_e;

    localparam int DEF_LINES      = 16;
    localparam int DEF_LINE_WORDS = 4;

    // Word-addressed: bits [1:0] of the byte address never reach the cache.
    function automatic int tag_bits(input int lines, input int line_words);
        return 30 - $clog2(lines) - $clog2(line_words);
    endfunction

endpackage

// File: rtl/icache_data_array.sv
// Instruction storage for the cache: one synchronous write port used by the
// refill path and one combinational read port used by the hit path.
module icache_data_array #(
    parameter int LINES      = 16,
    parameter int LINE_WORDS = 4,
    parameter int IDX_BITS   = $clog2(LINES),
    parameter int OFF_BITS   = $clog2(LINE_WORDS)
) (
    input  logic                clk,
    input  logic                we,
    input  logic [IDX_BITS-1:0] wr_idx,
    input  logic [OFF_BITS-1:0] wr_word,
    input  logic [31:0]         wr_data,
    input  logic [IDX_BITS-1:0] rd_idx,
    input  logic [OFF_BITS-1:0] rd_word,
    output logic [31:0]         rd_data
);

    logic [31:0] mem_q [LINES][LINE_WORDS];

    always_ff @(posedge clk) begin
        if (we) begin
            mem_q[wr_idx][wr_word] <= wr_data;
        end
    end

    assign rd_data = mem_q[rd_idx][rd_word];

endmodule

// File: rtl/icache_dm.sv
// Direct-mapped read-only instruction cache: single-cycle hits, blocking
// line refill over a valid/ready request and a beat-streamed response.
module icache_dm
    import icache_pkg::*;
#(
    parameter int LINES      = DEF_LINES,
    parameter int LINE_WORDS = DEF_LINE_WORDS
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] icache_addr,
    input  logic        icache_re,
    output logic [31:0] icache_dout,
    output logic        stall,
    input  logic        flush,
    output logic        mem_req_valid,
    input  logic        mem_req_ready,
    output logic [31:0] mem_req_addr,
    input  logic        mem_resp_valid,
    input  logic [31:0] mem_resp_data
);

    localparam int OFF_BITS = $clog2(LINE_WORDS);
    localparam int IDX_BITS = $clog2(LINES);
    localparam int TAG_BITS = tag_bits(LINES, LINE_WORDS);
    localparam logic [OFF_BITS-1:0] LAST_BEAT = OFF_BITS'(LINE_WORDS - 1);

    state_e              state_q, state_d;
    logic [31:2]         addr_q, addr_d;
    logic                req_pending_q, req_pending_d;
    logic [OFF_BITS-1:0] beat_cnt_q, beat_cnt_d;
    logic [31:0]         dout_q, dout_d;
    logic [31:0]         resp_word_q, resp_word_d;
    logic                flush_pending_q, flush_pending_d;
    logic [LINES-1:0]    valid_q, valid_d;
    logic [TAG_BITS-1:0] tag_q [LINES];

    logic                tag_we;
    logic                cap_en;
    logic                hit;
    logic                arr_we;
    logic [31:0]         rd_data;
    logic                addr_lo_unused;

    logic [OFF_BITS-1:0] req_off;
    logic [IDX_BITS-1:0] req_idx;
    logic [TAG_BITS-1:0] req_tag;

    assign addr_lo_unused = ^icache_addr[1:0];

    assign req_off = addr_q[OFF_BITS+1:2];
    assign req_idx = addr_q[OFF_BITS+IDX_BITS+1:OFF_BITS+2];
    assign req_tag = addr_q[31:32-TAG_BITS];

    assign hit         = valid_q[req_idx] && (tag_q[req_idx] == req_tag);
    assign arr_we      = (state_q == ST_REFILL) && mem_resp_valid;
    assign icache_dout = dout_q;

    icache_data_array #(
        .LINES      (LINES),
        .LINE_WORDS (LINE_WORDS)
    ) u_data (
        .clk     (clk),
        .we      (arr_we),
        .wr_idx  (req_idx),
        .wr_word (beat_cnt_q),
        .wr_data (mem_resp_data),
        .rd_idx  (req_idx),
        .rd_word (req_off),
        .rd_data (rd_data)
    );

    always_comb begin
        state_d         = state_q;
        addr_d          = addr_q;
        req_pending_d   = req_pending_q;
        beat_cnt_d      = beat_cnt_q;
        dout_d          = dout_q;
        resp_word_d     = resp_word_q;
        flush_pending_d = flush_pending_q;
        valid_d         = valid_q;
        tag_we          = 1'b0;
        cap_en          = 1'b0;
        stall           = 1'b0;
        mem_req_valid   = 1'b0;
        mem_req_addr    = '0;

        case (state_q)
            ST_IDLE: begin
                if (req_pending_q && !hit) begin
                    stall   = 1'b1;
                    state_d = ST_REQ;
                end else begin
                    cap_en = 1'b1;
                    if (req_pending_q) begin
                        dout_d = rd_data;
                    end
                end
                if (flush) begin
                    valid_d = '0;
                end
            end
            ST_REQ: begin
                stall         = 1'b1;
                mem_req_valid = 1'b1;
                mem_req_addr  = {req_tag, req_idx, {(OFF_BITS + 2){1'b0}}};
                if (mem_req_ready) begin
                    state_d    = ST_REFILL;
                    beat_cnt_d = '0;
                end
                if (flush) begin
                    flush_pending_d = 1'b1;
                end
            end
            ST_REFILL: begin
                stall = 1'b1;
                if (mem_resp_valid) begin
                    beat_cnt_d = beat_cnt_q + 1'b1;
                    // Keep the requested word aside so RESPOND never reads a just-written entry.
                    if (beat_cnt_q == req_off) begin
                        resp_word_d = mem_resp_data;
                    end
                    if (beat_cnt_q == LAST_BEAT) begin
                        tag_we           = 1'b1;
                        valid_d[req_idx] = 1'b1;
                        state_d          = ST_RESPOND;
                    end
                end
                if (flush) begin
                    flush_pending_d = 1'b1;
                end
            end
            ST_RESPOND: begin
                cap_en          = 1'b1;
                dout_d          = resp_word_q;
                state_d         = ST_IDLE;
                flush_pending_d = 1'b0;
                if (flush || flush_pending_q) begin
                    valid_d = '0;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        if (cap_en) begin
            req_pending_d = icache_re;
            if (icache_re) begin
                addr_d = icache_addr[31:2];
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q         <= ST_IDLE;
            addr_q          <= '0;
            req_pending_q   <= 1'b0;
            beat_cnt_q      <= '0;
            dout_q          <= '0;
            resp_word_q     <= '0;
            flush_pending_q <= 1'b0;
            valid_q         <= '0;
            for (int i = 0; i < LINES; i++) begin
                tag_q[i] <= '0;
            end
        end else begin
            state_q         <= state_d;
            addr_q          <= addr_d;
            req_pending_q   <= req_pending_d;
            beat_cnt_q      <= beat_cnt_d;
            dout_q          <= dout_d;
            resp_word_q     <= resp_word_d;
            flush_pending_q <= flush_pending_d;
            valid_q         <= valid_d;
            if (tag_we) begin
                tag_q[req_idx] <= req_tag;
            end
        end
    end

endmodule

// File: tb/tb_icache_dm.sv
// Directed bench for icache_dm: a line-level cache model predicts stall,
// memory request and returned word each cycle; literal checks pin the model.
module tb_icache_dm;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] icache_addr;
    logic        icache_re;
    logic [31:0] icache_dout;
    logic        stall;
    logic        flush;
    logic        mem_req_valid;
    logic        mem_req_ready;
    logic [31:0] mem_req_addr;
    logic        mem_resp_valid;
    logic [31:0] mem_resp_data;

    icache_dm dut (
        .clk            (clk),
        .reset          (reset),
        .icache_addr    (icache_addr),
        .icache_re      (icache_re),
        .icache_dout    (icache_dout),
        .stall          (stall),
        .flush          (flush),
        .mem_req_valid  (mem_req_valid),
        .mem_req_ready  (mem_req_ready),
        .mem_req_addr   (mem_req_addr),
        .mem_resp_valid (mem_resp_valid),
        .mem_resp_data  (mem_resp_data)
    );

    always #5 clk = ~clk;

    int vectors = 0;
    int errors  = 0;

    logic        exp_stall;
    logic        exp_mreq;
    logic [31:0] exp_maddr;
    logic [31:0] exp_dout;
    bit          chk_en = 1'b0;

    // Resident lines: index -> (valid, tag, four words).
    bit          mdl_valid [16];
    logic [23:0] mdl_tag   [16];
    logic [31:0] mdl_data  [16][4];

    function automatic logic [31:0] beat_val(input logic [31:0] line, input int w);
        case (line)
            32'h0000_0040: return 32'hA0 + 32'(w);
            32'h0000_0440: return 32'hB0 + 32'(w);
            default:       return line + 32'h1000_0000 + 32'(w);
        endcase
    endfunction

    function automatic logic [31:0] word_of(input logic [31:0] a);
        return mdl_data[a[7:4]][a[3:2]];
    endfunction

    task automatic invalidate_all();
        foreach (mdl_valid[i]) mdl_valid[i] = 1'b0;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %08h expected %08h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (chk_en) begin
            check("stall", 32'(stall), 32'(exp_stall));
            check("mem_req_valid", 32'(mem_req_valid), 32'(exp_mreq));
            if (exp_mreq || reset) check("mem_req_addr", mem_req_addr, exp_maddr);
            check("icache_dout", icache_dout, exp_dout);
        end
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    // n consecutive requests to base, base+4, ...; all must hit.
    task automatic hits(input logic [31:0] base, input int n, input bit fl);
        logic [31:0] a;
        a = base;
        for (int i = 0; i < n; i++) begin
            a           = base + 32'(4 * i);
            icache_addr = a;
            icache_re   = 1'b1;
            cyc();
            if (i > 0) exp_dout = word_of(a - 32'd4);
            exp_stall = 1'b0;
            exp_mreq  = 1'b0;
        end
        icache_re = 1'b0;
        flush     = fl;
        cyc();
        flush    = 1'b0;
        exp_dout = word_of(a);
        if (fl) invalidate_all();
    endtask

    task automatic access(input logic [31:0] a, input int dly, input int flush_beat, input int rst_beat);
        logic [3:0]  idx;
        logic [23:0] tg;
        logic [31:0] line;
        bit          fl_seen;
        idx     = a[7:4];
        tg      = a[31:8];
        line    = {a[31:4], 4'h0};
        fl_seen = 1'b0;
        if (mdl_valid[idx] && mdl_tag[idx] == tg) begin
            hits(a, 1, 1'b0);
            return;
        end
        icache_addr = a;
        icache_re   = 1'b1;
        cyc();
        exp_stall = 1'b1;
        exp_mreq  = 1'b0;
        cyc();
        exp_mreq  = 1'b1;
        exp_maddr = line;
        // Beats presented before the request is accepted must be ignored.
        mem_resp_valid = 1'b1;
        mem_resp_data  = 32'hDEAD_BEEF;
        for (int k = 0; k <= dly; k++) begin
            mem_req_ready = (k == dly);
            cyc();
        end
        mem_req_ready = 1'b0;
        exp_mreq      = 1'b0;
        for (int w = 0; w < 4; w++) begin
            mem_resp_valid = 1'b1;
            mem_resp_data  = beat_val(line, w);
            flush          = (w == flush_beat);
            if (w == flush_beat) fl_seen = 1'b1;
            cyc();
            flush          = 1'b0;
            mdl_data[idx][w] = beat_val(line, w);
            if (w == rst_beat) begin
                reset     = 1'b1;
                icache_re = 1'b0;
                #1;
                check("rst_stall", 32'(stall), 32'd0);
                check("rst_mreq", 32'(mem_req_valid), 32'd0);
                check("rst_dout", icache_dout, 32'd0);
                exp_stall = 1'b0;
                exp_mreq  = 1'b0;
                exp_maddr = 32'd0;
                exp_dout  = 32'd0;
                invalidate_all();
                mem_resp_data = beat_val(line, w + 1);
                cyc();
                reset = 1'b0;
                for (int j = w + 2; j < 4; j++) begin
                    mem_resp_data = beat_val(line, j);
                    cyc();
                end
                mem_resp_valid = 1'b0;
                return;
            end
        end
        mem_resp_valid = 1'b0;
        exp_stall      = 1'b0;
        mdl_valid[idx] = 1'b1;
        mdl_tag[idx]   = tg;
        icache_re      = 1'b0;
        cyc();
        exp_dout = word_of(a);
        if (fl_seen) invalidate_all();
    endtask

    initial begin
        reset          = 1'b1;
        icache_addr    = 32'd0;
        icache_re      = 1'b0;
        flush          = 1'b0;
        mem_req_ready  = 1'b0;
        mem_resp_valid = 1'b0;
        mem_resp_data  = 32'd0;
        exp_stall      = 1'b0;
        exp_mreq       = 1'b0;
        exp_maddr      = 32'd0;
        exp_dout       = 32'd0;
        invalidate_all();
        chk_en = 1'b1;
        cyc();
        cyc();
        reset = 1'b0;
        cyc();

        access(32'h0000_0040, 2, -1, -1);
        check("pin_cold_dout", icache_dout, 32'h0000_00A0);

        access(32'h0000_0048, 0, -1, -1);
        check("pin_hit_dout", icache_dout, 32'h0000_00A2);

        hits(32'h0000_0040, 4, 1'b0);
        check("pin_b2b_dout", icache_dout, 32'h0000_00A3);

        access(32'h0000_0440, 0, -1, -1);
        check("pin_conflict_dout", icache_dout, 32'h0000_00B0);

        access(32'h0000_0040, 1, -1, -1);
        check("pin_refetch_dout", icache_dout, 32'h0000_00A0);

        access(32'h0000_0084, 0, 2, -1);
        check("pin_flushfill_dout", icache_dout, 32'h1000_0081);
        access(32'h0000_0084, 0, -1, -1);
        access(32'h0000_0040, 0, -1, -1);

        hits(32'h0000_0048, 1, 1'b1);
        check("pin_flushhit_dout", icache_dout, 32'h0000_00A2);
        access(32'h0000_0048, 0, -1, -1);

        access(32'h0000_0440, 1, -1, 1);
        access(32'h0000_0440, 0, -1, -1);
        check("pin_after_reset_dout", icache_dout, 32'h0000_00B0);

        cyc();
        cyc();
        chk_en = 1'b0;
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
